// File: rtl/timer_multi_if.sv
// rtl/timer_multi_if.sv - switch, pulse and display signal bundle for the multi-mode timer
interface timer_multi_if #(
    parameter int HW = 5
);
    logic          mode_in;
    logic          start_stop;
    logic          dir_in;
    logic          hour_in;
    logic          min_in;
    logic          sec_in;
    logic [HW-1:0] hour_out;
    logic [5:0]    min_out;
    logic [5:0]    sec_out;
    logic [2:0]    state_out;
    logic          alarm;
    logic          dir_out;

    modport master (
        output mode_in, start_stop, dir_in, hour_in, min_in, sec_in,
        input  hour_out, min_out, sec_out, state_out, alarm, dir_out
    );

    modport slave (
        input  mode_in, start_stop, dir_in, hour_in, min_in, sec_in,
        output hour_out, min_out, sec_out, state_out, alarm, dir_out
    );
endinterface

// File: rtl/timer_multi.sv
// rtl/timer_multi.sv - settable countdown timer / stopwatch with timed alarm on a 1 Hz clock
module timer_multi #(
    parameter int HOUR_MAX   = 12,
    parameter int HW         = 5,
    parameter int ALARM_SECS = 10
) (
    input  logic          clk_1Hz,
    input  logic          reset,
    timer_multi_if.slave  bus
);
    localparam int             CW    = $clog2(ALARM_SECS + 1);
    localparam logic [HW-1:0]  HMAX  = HW'(HOUR_MAX);
    localparam logic [CW-1:0]  CLAST = CW'(ALARM_SECS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] hour_q, hour_d;
    logic [5:0]    min_q, min_d, sec_q, sec_d;
    logic          dir_q, dir_d, alarm_q, alarm_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [HW-1:0] set_h, dn_h, up_h;
    logic [5:0]    set_m, set_s, dn_m, dn_s, up_m, up_s;
    logic          time_zero, dn_end, up_end;

    always_comb begin
        time_zero = (hour_q == '0) && (min_q == 6'd0) && (sec_q == 6'd0);

        set_h = bus.hour_in ? ((hour_q == HMAX) ? '0 : hour_q + 1'b1) : hour_q;
        set_m = bus.min_in  ? ((min_q == 6'd59) ? 6'd0 : min_q + 6'd1) : min_q;
        set_s = bus.sec_in  ? ((sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1) : sec_q;
        if (set_h == HMAX) begin
            set_m = 6'd0;
            set_s = 6'd0;
        end

        // Countdown saturates at zero so a resume at 0:00:00 cannot underflow.
        dn_h = hour_q;
        dn_m = min_q;
        dn_s = sec_q;
        if (sec_q != 6'd0) begin
            dn_s = sec_q - 6'd1;
        end else if (min_q != 6'd0) begin
            dn_m = min_q - 6'd1;
            dn_s = 6'd59;
        end else if (hour_q != '0) begin
            dn_h = hour_q - 1'b1;
            dn_m = 6'd59;
            dn_s = 6'd59;
        end
        dn_end = time_zero || ((hour_q == '0) && (min_q == 6'd0) && (sec_q == 6'd1));

        up_h = hour_q;
        up_m = min_q;
        up_s = sec_q;
        if (hour_q != HMAX) begin
            if (sec_q != 6'd59) begin
                up_s = sec_q + 6'd1;
            end else begin
                up_s = 6'd0;
                if (min_q != 6'd59) begin
                    up_m = min_q + 6'd1;
                end else begin
                    up_m = 6'd0;
                    up_h = hour_q + 1'b1;
                end
            end
        end
        up_end = (up_h == HMAX) && (up_m == 6'd0) && (up_s == 6'd0);
    end

    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                hour_d = '0;
                min_d  = 6'd0;
                sec_d  = 6'd0;
                if (bus.mode_in) state_d = S_SET;
            end
            S_SET: begin
                dir_d = bus.dir_in;
                if (!bus.mode_in) begin
                    state_d = S_IDLE;
                    hour_d  = '0;
                    min_d   = 6'd0;
                    sec_d   = 6'd0;
                end else begin
                    hour_d = set_h;
                    min_d  = set_m;
                    sec_d  = set_s;
                    if (bus.start_stop && !time_zero) state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!bus.mode_in) begin
                    state_d = S_IDLE;
                    hour_d  = '0;
                    min_d   = 6'd0;
                    sec_d   = 6'd0;
                end else begin
                    hour_d = dir_q ? up_h : dn_h;
                    min_d  = dir_q ? up_m : dn_m;
                    sec_d  = dir_q ? up_s : dn_s;
                    if (!bus.start_stop) begin
                        state_d = S_PAUSE;
                    end else if (dir_q ? up_end : dn_end) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end
                end
            end
            S_PAUSE: begin
                if (!bus.mode_in) begin
                    state_d = S_IDLE;
                    hour_d  = '0;
                    min_d   = 6'd0;
                    sec_d   = 6'd0;
                end else if (bus.start_stop) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (!bus.mode_in || (cnt_q == CLAST)) begin
                    state_d = S_IDLE;
                    hour_d  = '0;
                    min_d   = 6'd0;
                    sec_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        alarm_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_1Hz) begin
        if (reset) begin
            state_q <= S_IDLE;
            hour_q  <= '0;
            min_q   <= 6'd0;
            sec_q   <= 6'd0;
            dir_q   <= 1'b0;
            alarm_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            dir_q   <= dir_d;
            alarm_q <= alarm_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.hour_out  = hour_q;
    assign bus.min_out   = min_q;
    assign bus.sec_out   = sec_q;
    assign bus.state_out = state_q;
    assign bus.alarm     = alarm_q;
    assign bus.dir_out   = dir_q;
endmodule

// File: tb/tb_timer_multi.sv
// tb/tb_timer_multi.sv - directed checks of timer_multi with HOUR_MAX=12 and HOUR_MAX=1 instances
module tb_timer_multi;
    logic clk = 1'b0;
    logic reset;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    timer_multi_if #(.HW(5)) ia ();
    timer_multi_if #(.HW(5)) ib ();

    timer_multi #(.HOUR_MAX(12), .HW(5), .ALARM_SECS(10)) dut_a (
        .clk_1Hz (clk),
        .reset   (reset),
        .bus     (ia.slave)
    );

    timer_multi #(.HOUR_MAX(1), .HW(5), .ALARM_SECS(10)) dut_b (
        .clk_1Hz (clk),
        .reset   (reset),
        .bus     (ib.slave)
    );

    function automatic logic [16:0] hms(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        compared++;
        if (ia.state_out !== 3'd0) begin
            mismatched++; $display("FAIL rst_state_a got=%0d exp=0", ia.state_out);
        end
        compared++;
        if ({ia.hour_out, ia.min_out, ia.sec_out} !== hms(0, 0, 0)) begin
            mismatched++; $display("FAIL rst_time_a got=%h exp=%h", {ia.hour_out, ia.min_out, ia.sec_out}, hms(0, 0, 0));
        end
        compared++;
        if ({ia.alarm, ia.dir_out, ib.alarm, ib.dir_out} !== 4'b0000) begin
            mismatched++; $display("FAIL rst_flags got=%b exp=0000", {ia.alarm, ia.dir_out, ib.alarm, ib.dir_out});
        end
        compared++;
        if (ib.state_out !== 3'd0) begin
            mismatched++; $display("FAIL rst_state_b got=%0d exp=0", ib.state_out);
        end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_countdown();
        ia.mode_in = 1'b1;
        step(1);
        compared++;
        if (ia.state_out !== 3'd1) begin
            mismatched++; $display("FAIL cd_enter_set got=%0d exp=1", ia.state_out);
        end
        ia.min_in = 1'b1;
        step(1);
        ia.min_in = 1'b0;
        ia.sec_in = 1'b1;
        step(2);
        ia.sec_in = 1'b0;
        compared++;
        if ({ia.hour_out, ia.min_out, ia.sec_out} !== hms(0, 1, 2)) begin
            mismatched++; $display("FAIL cd_preset got=%h exp=%h", {ia.hour_out, ia.min_out, ia.sec_out}, hms(0, 1, 2));
        end
        ia.start_stop = 1'b1;
        step(1);
        compared++;
        if (ia.state_out !== 3'd2 || {ia.hour_out, ia.min_out, ia.sec_out} !== hms(0, 1, 2)) begin
            mismatched++; $display("FAIL cd_start got=%0d/%h exp=2/%h", ia.state_out, {ia.hour_out, ia.min_out, ia.sec_out}, hms(0, 1, 2));
        end
        step(1);
        compared++;
        if ({ia.hour_out, ia.min_out, ia.sec_out} !== hms(0, 1, 1)) begin
            mismatched++; $display("FAIL cd_t1 got=%h exp=%h", {ia.hour_out, ia.min_out, ia.sec_out}, hms(0, 1, 1));
        end
        step(1);
        compared++;
        if ({ia.hour_out, ia.min_out, ia.sec_out} !== hms(0, 1, 0)) begin
            mismatched++; $display("FAIL cd_t2 got=%h exp=%h", {ia.hour_out, ia.min_out, ia.sec_out}, hms(0, 1, 0));
        end
        step(1);
        compared++;
        if ({ia.hour_out, ia.min_out, ia.sec_out} !== hms(0, 0, 59)) begin
            mismatched++; $display("FAIL cd_borrow got=%h exp=%h", {ia.hour_out, ia.min_out, ia.sec_out}, hms(0, 0, 59));
        end
        step(58);
        compared++;
        if (ia.state_out !== 3'd2 || {ia.hour_out, ia.min_out, ia.sec_out} !== hms(0, 0, 1)) begin
            mismatched++; $display("FAIL cd_last got=%0d/%h exp=2/%h", ia.state_out, {ia.hour_out, ia.min_out, ia.sec_out}, hms(0, 0, 1));
        end
        step(1);
        compared++;
        if (ia.state_out !== 3'd4 || ia.alarm !== 1'b1 || {ia.hour_out, ia.min_out, ia.sec_out} !== hms(0, 0, 0)) begin
            mismatched++; $display("FAIL cd_done got=%0d/%b/%h exp=4/1/%h", ia.state_out, ia.alarm, {ia.hour_out, ia.min_out, ia.sec_out}, hms(0, 0, 0));
        end
        step(9);
        compared++;
        if (ia.state_out !== 3'd4 || ia.alarm !== 1'b1) begin
            mismatched++; $display("FAIL cd_alarm_tail got=%0d/%b exp=4/1", ia.state_out, ia.alarm);
        end
        step(1);
        compared++;
        if (ia.state_out !== 3'd0 || ia.alarm !== 1'b0) begin
            mismatched++; $display("FAIL cd_alarm_end got=%0d/%b exp=0/0", ia.state_out, ia.alarm);
        end
        ia.mode_in = 1'b0;
        ia.start_stop = 1'b0;
        step(2);
    endtask

    task automatic test_cap_and_guard();
        ia.mode_in = 1'b1;
        step(1);
        ia.min_in = 1'b1;
        step(30);
        ia.min_in = 1'b0;
        ia.sec_in = 1'b1;
        step(15);
        ia.sec_in = 1'b0;
        compared++;
        if ({ia.hour_out, ia.min_out, ia.sec_out} !== hms(0, 30, 15)) begin
            mismatched++; $display("FAIL cap_preset got=%h exp=%h", {ia.hour_out, ia.min_out, ia.sec_out}, hms(0, 30, 15));
        end
        ia.hour_in = 1'b1;
        step(11);
        compared++;
        if ({ia.hour_out, ia.min_out, ia.sec_out} !== hms(11, 30, 15)) begin
            mismatched++; $display("FAIL cap_h11 got=%h exp=%h", {ia.hour_out, ia.min_out, ia.sec_out}, hms(11, 30, 15));
        end
        step(1);
        ia.hour_in = 1'b0;
        compared++;
        if ({ia.hour_out, ia.min_out, ia.sec_out} !== hms(12, 0, 0)) begin
            mismatched++; $display("FAIL cap_h12 got=%h exp=%h", {ia.hour_out, ia.min_out, ia.sec_out}, hms(12, 0, 0));
        end
        ia.min_in = 1'b1;
        step(1);
        ia.min_in = 1'b0;
        compared++;
        if ({ia.hour_out, ia.min_out, ia.sec_out} !== hms(12, 0, 0)) begin
            mismatched++; $display("FAIL cap_min_ignored got=%h exp=%h", {ia.hour_out, ia.min_out, ia.sec_out}, hms(12, 0, 0));
        end
        ia.hour_in = 1'b1;
        step(1);
        ia.hour_in = 1'b0;
        compared++;
        if ({ia.hour_out, ia.min_out, ia.sec_out} !== hms(0, 0, 0)) begin
            mismatched++; $display("FAIL cap_hour_wrap got=%h exp=%h", {ia.hour_out, ia.min_out, ia.sec_out}, hms(0, 0, 0));
        end
        ia.start_stop = 1'b1;
        step(1);
        ia.start_stop = 1'b0;
        compared++;
        if (ia.state_out !== 3'd1) begin
            mismatched++; $display("FAIL guard_zero got=%0d exp=1", ia.state_out);
        end
        {ia.hour_in, ia.min_in, ia.sec_in} = 3'b111;
        step(1);
        {ia.hour_in, ia.min_in, ia.sec_in} = 3'b000;
        compared++;
        if ({ia.hour_out, ia.min_out, ia.sec_out} !== hms(1, 1, 1)) begin
            mismatched++; $display("FAIL simul_pulses got=%h exp=%h", {ia.hour_out, ia.min_out, ia.sec_out}, hms(1, 1, 1));
        end
        ia.mode_in = 1'b0;
        step(1);
        compared++;
        if (ia.state_out !== 3'd0 || {ia.hour_out, ia.min_out, ia.sec_out} !== hms(0, 0, 0)) begin
            mismatched++; $display("FAIL set_abort got=%0d/%h exp=0/%h", ia.state_out, {ia.hour_out, ia.min_out, ia.sec_out}, hms(0, 0, 0));
        end
    endtask

    task automatic test_stopwatch();
        ib.dir_in = 1'b1;
        ib.mode_in = 1'b1;
        step(1);
        ib.min_in = 1'b1;
        ib.sec_in = 1'b1;
        step(58);
        ib.sec_in = 1'b0;
        step(1);
        ib.min_in = 1'b0;
        compared++;
        if ({ib.hour_out, ib.min_out, ib.sec_out} !== hms(0, 59, 58) || ib.dir_out !== 1'b1) begin
            mismatched++; $display("FAIL sw_preset got=%h/%b exp=%h/1", {ib.hour_out, ib.min_out, ib.sec_out}, ib.dir_out, hms(0, 59, 58));
        end
        ib.start_stop = 1'b1;
        step(2);
        compared++;
        if (ib.state_out !== 3'd2 || {ib.hour_out, ib.min_out, ib.sec_out} !== hms(0, 59, 59)) begin
            mismatched++; $display("FAIL sw_t1 got=%0d/%h exp=2/%h", ib.state_out, {ib.hour_out, ib.min_out, ib.sec_out}, hms(0, 59, 59));
        end
        step(1);
        compared++;
        if (ib.state_out !== 3'd4 || ib.alarm !== 1'b1 || {ib.hour_out, ib.min_out, ib.sec_out} !== hms(1, 0, 0)) begin
            mismatched++; $display("FAIL sw_done got=%0d/%b/%h exp=4/1/%h", ib.state_out, ib.alarm, {ib.hour_out, ib.min_out, ib.sec_out}, hms(1, 0, 0));
        end
        ib.mode_in = 1'b0;
        step(1);
        compared++;
        if (ib.state_out !== 3'd0 || ib.alarm !== 1'b0 || ib.dir_out !== 1'b1 || {ib.hour_out, ib.min_out, ib.sec_out} !== hms(0, 0, 0)) begin
            mismatched++; $display("FAIL sw_done_abort got=%0d/%b/%b/%h exp=0/0/1/%h", ib.state_out, ib.alarm, ib.dir_out, {ib.hour_out, ib.min_out, ib.sec_out}, hms(0, 0, 0));
        end
        ib.start_stop = 1'b0;
    endtask

    task automatic test_pause_abort();
        ia.mode_in = 1'b1;
        step(1);
        ia.sec_in = 1'b1;
        step(30);
        ia.sec_in = 1'b0;
        ia.start_stop = 1'b1;
        step(1);
        ia.start_stop = 1'b0;
        step(1);
        compared++;
        if (ia.state_out !== 3'd3 || {ia.hour_out, ia.min_out, ia.sec_out} !== hms(0, 0, 29)) begin
            mismatched++; $display("FAIL pause_enter got=%0d/%h exp=3/%h", ia.state_out, {ia.hour_out, ia.min_out, ia.sec_out}, hms(0, 0, 29));
        end
        step(4);
        compared++;
        if (ia.state_out !== 3'd3 || {ia.hour_out, ia.min_out, ia.sec_out} !== hms(0, 0, 29)) begin
            mismatched++; $display("FAIL pause_hold got=%0d/%h exp=3/%h", ia.state_out, {ia.hour_out, ia.min_out, ia.sec_out}, hms(0, 0, 29));
        end
        ia.start_stop = 1'b1;
        step(2);
        compared++;
        if (ia.state_out !== 3'd2 || {ia.hour_out, ia.min_out, ia.sec_out} !== hms(0, 0, 28)) begin
            mismatched++; $display("FAIL resume got=%0d/%h exp=2/%h", ia.state_out, {ia.hour_out, ia.min_out, ia.sec_out}, hms(0, 0, 28));
        end
        ia.mode_in = 1'b0;
        step(1);
        compared++;
        if (ia.state_out !== 3'd0 || {ia.hour_out, ia.min_out, ia.sec_out} !== hms(0, 0, 0)) begin
            mismatched++; $display("FAIL run_abort got=%0d/%h exp=0/%h", ia.state_out, {ia.hour_out, ia.min_out, ia.sec_out}, hms(0, 0, 0));
        end
        ia.start_stop = 1'b0;
    endtask

    task automatic test_reset_in_done();
        ia.mode_in = 1'b1;
        step(1);
        ia.sec_in = 1'b1;
        step(2);
        ia.sec_in = 1'b0;
        ia.start_stop = 1'b1;
        step(3);
        compared++;
        if (ia.state_out !== 3'd4 || ia.alarm !== 1'b1) begin
            mismatched++; $display("FAIL rd_done got=%0d/%b exp=4/1", ia.state_out, ia.alarm);
        end
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        compared++;
        if (ia.state_out !== 3'd0 || ia.alarm !== 1'b0 || {ia.hour_out, ia.min_out, ia.sec_out} !== hms(0, 0, 0)) begin
            mismatched++; $display("FAIL rd_reset got=%0d/%b/%h exp=0/0/%h", ia.state_out, ia.alarm, {ia.hour_out, ia.min_out, ia.sec_out}, hms(0, 0, 0));
        end
        step(1);
        compared++;
        if (ia.state_out !== 3'd1) begin
            mismatched++; $display("FAIL rd_after_reset got=%0d exp=1", ia.state_out);
        end
        ia.start_stop = 1'b0;
        ia.mode_in = 1'b0;
        step(1);
    endtask

    initial begin
        reset = 1'b1;
        {ia.mode_in, ia.start_stop, ia.dir_in, ia.hour_in, ia.min_in, ia.sec_in} = 6'b0;
        {ib.mode_in, ib.start_stop, ib.dir_in, ib.hour_in, ib.min_in, ib.sec_in} = 6'b0;
        step(1);
        test_reset();
        test_countdown();
        test_cap_and_guard();
        test_stopwatch();
        test_pause_abort();
        test_reset_in_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout compared=%0d exp=completion", compared);
        $fatal(1);
    end
endmodule
